pc_unit: RTL and testbench

- Parametrised program-counter unit, the next generation of the single-cycle PC register.
- Holds the current PC and selects the next PC from five sources: sequential, branch, jump, register and return.
- Includes a circular return-address stack (RAS) for call/return prediction-free return addressing.
- Sits between the control unit and the instruction memory; cur_pc drives the instruction fetch address.

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_ras.sv | 77 +++++++
 rtl/pc_unit.sv | 95 +++++++++
 tb/tb_pc_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC source encoding,
// PC increment and branch-offset helper.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SRC_SEQ    = 3'd0,
    PC_SRC_BRANCH = 3'd1,
    PC_SRC_JUMP   = 3'd2,
    PC_SRC_REG    = 3'd3,
    PC_SRC_RET    = 3'd4
  } pc_src_e;

  localparam int unsigned PC_INC = 4;

  // Sign-extends the low imm_w bits of imm and converts words to bytes.
  function automatic logic [63:0] sext_shl2(input logic [63:0] imm, input int unsigned imm_w);
    logic signed [63:0] t;
    t = $signed(imm << (64 - imm_w));
    t = t >>> (64 - imm_w);
    return 64'(t <<< 2);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, same-cycle replace and a
// registered underflow pulse. Pushing while full overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [PC_W-1:0]            push_data_i,
  output logic [PC_W-1:0]            top_o,
  output logic [$clog2(RAS_DEPTH):0] count_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       underflow_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, top_idx, wr_idx;
  logic [PTR_W:0]   count_q, count_d;
  logic             underflow_q, underflow_d, wr_en;

  assign top_idx     = ptr_q - PTR_W'(1);
  assign top_o       = mem_q[top_idx];
  assign count_o     = count_q;
  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == (PTR_W+1)'(RAS_DEPTH));
  assign underflow_o = underflow_q;

  always_comb begin
    ptr_d       = ptr_q;
    count_d     = count_q;
    underflow_d = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = ptr_q;
    if (we_i) begin
      // A call and return in one cycle replaces the top; on an empty stack the
      // pop underflows and the push proceeds as a plain push.
      if (push_i && pop_i && !empty_o) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (push_i) begin
        wr_en       = 1'b1;
        ptr_d       = ptr_q + PTR_W'(1);
        underflow_d = pop_i;
        if (!full_o) count_d = count_q + (PTR_W+1)'(1);
      end else if (pop_i) begin
        if (empty_o) begin
          underflow_d = 1'b1;
        end else begin
          ptr_d   = top_idx;
          count_d = count_q - (PTR_W+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
      if (wr_en) mem_q[wr_idx] <= push_data_i;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, PC register and return-address stack.
// Optional misalignment trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     PC_W      = 32,
  parameter int unsigned     IMM_W     = 16,
  parameter int unsigned     JADDR_W   = 26,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(32'h0000_0100)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pc_we,
  input  logic [2:0]                 pc_src,
  input  logic [IMM_W-1:0]           br_imm,
  input  logic [JADDR_W-1:0]         j_addr,
  input  logic [PC_W-1:0]            reg_target,
  input  logic                       ras_push,
  output logic [PC_W-1:0]            cur_pc,
  output logic [PC_W-1:0]            pc_plus4,
  output logic [PC_W-1:0]            next_pc,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_empty,
  output logic                       ras_full,
  output logic                       ras_underflow,
  output logic                       misalign
);

  logic [PC_W-1:0] cur_pc_q, sel_pc, br_tgt, jump_tgt, ras_top;
  logic            ras_pop;

  assign cur_pc   = cur_pc_q;
  assign pc_plus4 = cur_pc_q + PC_W'(PC_INC);
  assign br_tgt   = pc_plus4 + PC_W'(sext_shl2(64'(br_imm), IMM_W));
  assign ras_pop  = (pc_src == PC_SRC_RET);

  if (PC_W > JADDR_W + 2) begin : g_jump_full
    assign jump_tgt = {pc_plus4[PC_W-1:JADDR_W+2], j_addr, 2'b00};
  end else begin : g_jump_trunc
    logic [JADDR_W+1:0] jt;
    assign jt       = {j_addr, 2'b00};
    assign jump_tgt = jt[PC_W-1:0];
  end

  always_comb begin
    sel_pc = pc_plus4;
    case (pc_src)
      PC_SRC_BRANCH: sel_pc = br_tgt;
      PC_SRC_JUMP:   sel_pc = jump_tgt;
      PC_SRC_REG:    sel_pc = reg_target;
      PC_SRC_RET:    sel_pc = ras_empty ? reg_target : ras_top;
      default:       sel_pc = pc_plus4;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic trap, misalign_q;
  assign trap     = (sel_pc[1:0] != 2'b00);
  assign next_pc  = trap ? TRAP_VEC : sel_pc;
  assign misalign = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= pc_we & trap;
  end
`else
  assign next_pc  = sel_pc;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)        cur_pc_q <= RESET_VEC;
    else if (pc_we) cur_pc_q <= next_pc;
  end

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .we_i        (pc_we),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_plus4),
    .top_o       (ras_top),
    .count_o     (ras_count),
    .empty_o     (ras_empty),
    .full_o      (ras_full),
    .underflow_o (ras_underflow)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, hand sequences and
// randomized stimulus against a queue-based reference model.
module tb_pc_unit;

  localparam int unsigned PC_W = 32, IMM_W = 16, JADDR_W = 26, DEPTH = 4;
  localparam bit [31:0] RESET_V = 32'h0, TRAP_V = 32'h100;

  logic              clk = 1'b0;
  logic              rst, pc_we, ras_push;
  logic [2:0]        pc_src;
  logic [IMM_W-1:0]  br_imm;
  logic [JADDR_W-1:0] j_addr;
  logic [PC_W-1:0]   reg_target, cur_pc, pc_plus4, next_pc;
  logic [2:0]        ras_count;
  logic              ras_empty, ras_full, ras_underflow, misalign;

  always #5 clk = ~clk;

  pc_unit #(
    .PC_W(32), .IMM_W(16), .JADDR_W(26), .RAS_DEPTH(4),
    .RESET_VEC(32'h0), .TRAP_VEC(32'h100)
  ) dut (
    .clk(clk), .rst(rst), .pc_we(pc_we), .pc_src(pc_src), .br_imm(br_imm),
    .j_addr(j_addr), .reg_target(reg_target), .ras_push(ras_push),
    .cur_pc(cur_pc), .pc_plus4(pc_plus4), .next_pc(next_pc),
    .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_underflow(ras_underflow), .misalign(misalign)
  );

  int passed = 0, total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Reference model: PC plus a bounded queue holding the stack, newest at the back.
  bit [31:0] m_pc;
  bit [31:0] stk[$];
  bit        m_uf, m_mis;

  function automatic bit [31:0] raw_target(bit [2:0] src, bit [15:0] imm, bit [25:0] ja, bit [31:0] rt);
    bit [31:0] p4;
    p4 = m_pc + 32'd4;
    case (src)
      3'd1: return p4 + 32'(int'($signed(imm)) * 4);
      3'd2: return (p4 & 32'hF000_0000) | (32'(ja) << 2);
      3'd3: return rt;
      3'd4: return (stk.size() > 0) ? stk[$] : rt;
      default: return p4;
    endcase
  endfunction

  function automatic bit is_trap(bit [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
    return (t % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input bit r, input bit we, input bit [2:0] src, input bit [15:0] imm,
                      input bit [25:0] ja, input bit [31:0] rt, input bit push);
    bit [31:0] t, p4;
    rst = r; pc_we = we; pc_src = src; br_imm = imm; j_addr = ja; reg_target = rt; ras_push = push;
    @(negedge clk);
    t  = raw_target(src, imm, ja, rt);
    p4 = m_pc + 32'd4;
    if (!r && we) begin
      chk("next_pc", next_pc, is_trap(t) ? TRAP_V : t);
      chk("pc_plus4", pc_plus4, p4);
    end
    m_uf = 0; m_mis = 0;
    if (r) begin
      m_pc = RESET_V; stk.delete();
    end else if (we) begin
      if (src == 3'd4 && push) begin
        if (stk.size() > 0) stk[$] = p4;
        else begin m_uf = 1; stk.push_back(p4); end
      end else if (push) begin
        stk.push_back(p4);
        if (stk.size() > DEPTH) void'(stk.pop_front());
      end else if (src == 3'd4) begin
        if (stk.size() > 0) void'(stk.pop_back());
        else m_uf = 1;
      end
      m_mis = is_trap(t);
      m_pc  = m_mis ? TRAP_V : t;
    end
    @(posedge clk); #1;
    chk("cur_pc", cur_pc, m_pc);
    chk("ras_count", ras_count, stk.size());
    chk("ras_empty", ras_empty, stk.size() == 0);
    chk("ras_full", ras_full, stk.size() == DEPTH);
    chk("ras_underflow", ras_underflow, m_uf);
    chk("misalign", misalign, m_mis);
  endtask

  typedef struct {
    bit r, we; bit [2:0] src; bit [15:0] imm; bit [25:0] ja; bit [31:0] rt; bit push;
    bit [31:0] exp_pc; bit [2:0] exp_cnt;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit we, bit [2:0] src, bit [15:0] imm, bit [25:0] ja,
                              bit [31:0] rt, bit push, bit [31:0] exp_pc, bit [2:0] exp_cnt);
    vec_t v;
    v.r = r; v.we = we; v.src = src; v.imm = imm; v.ja = ja; v.rt = rt; v.push = push;
    v.exp_pc = exp_pc; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  initial begin
    bit [31:0] rt;
    vecs.push_back(mk(1,1,0,0,0,0,0, 32'h0, 0));
    vecs.push_back(mk(0,1,0,0,0,0,0, 32'h4, 0));
    vecs.push_back(mk(0,1,0,0,0,0,0, 32'h8, 0));
    vecs.push_back(mk(0,1,0,0,0,0,0, 32'hC, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'hC, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'hC, 0));
    vecs.push_back(mk(0,1,3,0,0,32'h100,0, 32'h100, 0));
    vecs.push_back(mk(0,1,1,16'hFFFE,0,0,0, 32'hFC, 0));
    vecs.push_back(mk(0,1,3,0,0,32'h100,0, 32'h100, 0));
    vecs.push_back(mk(0,1,2,0,26'h40,0,0, 32'h100, 0));
    vecs.push_back(mk(0,1,3,0,0,32'hFFFF_FFFC,0, 32'hFFFF_FFFC, 0));
    vecs.push_back(mk(0,1,0,0,0,0,0, 32'h0, 0));
    vecs.push_back(mk(0,1,3,0,0,32'h10,0, 32'h10, 0));
    vecs.push_back(mk(0,1,3,0,0,32'h20,1, 32'h20, 1));
    vecs.push_back(mk(0,1,3,0,0,32'h30,1, 32'h30, 2));
    vecs.push_back(mk(0,1,3,0,0,32'h40,1, 32'h40, 3));
    vecs.push_back(mk(0,1,3,0,0,32'h50,1, 32'h50, 4));
    vecs.push_back(mk(0,1,3,0,0,32'h60,1, 32'h60, 4));
    vecs.push_back(mk(0,1,4,0,0,0,0, 32'h54, 3));
    vecs.push_back(mk(0,1,4,0,0,0,0, 32'h44, 2));
    vecs.push_back(mk(0,1,4,0,0,0,0, 32'h34, 1));
    vecs.push_back(mk(0,1,4,0,0,0,0, 32'h24, 0));
    vecs.push_back(mk(0,1,4,0,0,32'h200,0, 32'h200, 0));
    vecs.push_back(mk(0,1,3,0,0,32'h300,1, 32'h300, 1));
    vecs.push_back(mk(0,1,3,0,0,32'h400,1, 32'h400, 2));
    vecs.push_back(mk(0,1,4,0,0,0,1, 32'h304, 2));
    vecs.push_back(mk(0,1,4,0,0,0,0, 32'h404, 1));
    vecs.push_back(mk(0,1,3,0,0,32'h500,1, 32'h500, 2));
    vecs.push_back(mk(0,1,3,0,0,32'h600,1, 32'h600, 3));
    vecs.push_back(mk(1,1,3,0,0,32'h700,1, 32'h0, 0));
`ifdef PC_MISALIGN_TRAP_EN
    vecs.push_back(mk(0,1,3,0,0,32'h102,0, 32'h100, 0));
`else
    vecs.push_back(mk(0,1,3,0,0,32'h102,0, 32'h102, 0));
`endif

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].we, vecs[i].src, vecs[i].imm, vecs[i].ja, vecs[i].rt, vecs[i].push);
      chk($sformatf("vec%0d_pc", i), cur_pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_cnt", i), ras_count, vecs[i].exp_cnt);
    end

    // Underflow pulse lasts exactly one cycle.
    step(1,1,0,0,0,0,0);
    step(0,1,4,0,0,32'h200,0);
    chk("uf_pulse", ras_underflow, 1'b1);
    step(0,1,0,0,0,0,0);
    chk("uf_clear", ras_underflow, 1'b0);
    chk("uf_pc", cur_pc, 32'h204);

    // A stall with push and return requested changes nothing.
    step(0,1,3,0,0,32'h800,1);
    step(0,0,4,0,0,32'h900,1);
    chk("stall_pc", cur_pc, 32'h800);
    chk("stall_cnt", ras_count, 3'd1);
    step(0,1,4,0,0,0,0);
    chk("stall_ret", cur_pc, 32'h208);

    for (int n = 0; n < 400; n++) begin
      rt = $urandom;
      if ($urandom_range(0, 9) != 0) rt[1:0] = 2'b00;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)),
           16'($urandom), 26'($urandom), rt, $urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
